// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the parametrised router control FSM.
//   - state_t         : FSM state encoding (DA, LFD, LD, FFS, LAF, LP, CPE,
//                       WTE, DROP)
//   - STATE_W         : width of the state register
//   - DEFAULT_NUM_PORTS / DEFAULT_TIMEOUT_CYCLES : parameter defaults
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int STATE_W                = 4;
  localparam int DEFAULT_NUM_PORTS      = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [STATE_W-1:0] {
    DA   = 4'd0,  // DECODE_ADDRESS
    LFD  = 4'd1,  // LOAD_FIRST_DATA
    LD   = 4'd2,  // LOAD_DATA
    FFS  = 4'd3,  // FIFO_FULL_STATE
    LAF  = 4'd4,  // LOAD_AFTER_FULL
    LP   = 4'd5,  // LOAD_PARITY
    CPE  = 4'd6,  // CHECK_PARITY_ERROR
    WTE  = 4'd7,  // WAIT_TILL_EMPTY
    DROP = 4'd8   // discard packet with invalid address
  } state_t;

endpackage

// File: rtl/router_wait_timer.sv
// ---------------------------------------------------------------------------
// router_wait_timer
//   Clear/enable cycle counter with a terminal-count pulse. tc is high in the
//   enabled cycle in which the count equals LIMIT-1.
//   Ports:
//     clock  : system clock
//     resetn : asynchronous active-low reset
//     clr    : synchronous clear (wins over en)
//     en     : count enable
//     tc     : terminal count reached in this cycle
// ---------------------------------------------------------------------------
module router_wait_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      // Wraps after tc; the FSM leaves the wait state on tc anyway.
      if (count_reg == CNT_W'(LIMIT - 1)) count_reg <= '0;
      else                                count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = en && (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/router_fsm_np.sv
// ---------------------------------------------------------------------------
// router_fsm_np
//   Control FSM for a 1xNUM_PORTS packet router: header decode, first data,
//   payload, FIFO-full stall, parity load/check. Packets with an out-of-range
//   address are dropped, the destination is latched, a per-port soft reset
//   aborts the packet in flight, and optionally a wait-till-empty timeout
//   drops packets whose FIFO never drains.
//
//   Optional feature macro: ROUTER_FSM_WAIT_TIMEOUT_EN
//     defined   -> WTE times out after TIMEOUT_CYCLES cycles into DROP
//     undefined -> WTE waits forever, timeout_pulse tied 0
//
//   Ports:
//     clock, resetn        : clock, asynchronous active-low reset
//     pkt_valid            : packet byte valid from source
//     data_in              : header address field (sampled in DA)
//     fifo_full            : full flag of the selected FIFO
//     fifo_empty           : per-port FIFO empty flags
//     soft_reset           : per-port soft reset from the synchroniser
//     parity_done          : parity byte loaded
//     low_packet_valid     : pkt_valid fell during full/after-full
//     dest_addr            : latched destination port (registered)
//     write_enb_reg .. busy: state decodes
//     drop_state           : packet being discarded
//     timeout_pulse        : wait timeout fired this cycle
// ---------------------------------------------------------------------------
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS      = DEFAULT_NUM_PORTS,
  parameter int ADDR_W         = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic [ADDR_W-1:0]    dest_addr,
  output logic                 write_enb_reg,
  output logic                 detect_add,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 lfd_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic                 drop_state,
  output logic                 timeout_pulse
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("router_fsm_np: parameter out of range");
  end

  state_t state_reg, state_next;
  logic [ADDR_W-1:0] dest_addr_reg;

  // One-hot port match vectors. Selecting through a match vector keeps an
  // out-of-range header address from indexing past fifo_empty; it also makes
  // "address valid" simply "some port matched".
  logic [NUM_PORTS-1:0] hdr_match;
  logic [NUM_PORTS-1:0] dest_match;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign hdr_match[gi]  = (data_in == ADDR_W'(gi));
    assign dest_match[gi] = (dest_addr_reg == ADDR_W'(gi));
  end

  logic addr_valid, hdr_empty, dest_empty, dest_soft, abort, timeout_fire;

  assign addr_valid = |hdr_match;
  assign hdr_empty  = |(hdr_match & fifo_empty);
  assign dest_empty = |(dest_match & fifo_empty);
  assign dest_soft  = |(dest_match & soft_reset);

  // DROP never latched a usable address, so soft reset cannot apply there.
  assign abort = dest_soft && (state_reg != DA) && (state_reg != DROP);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic wait_tc;

  // Held clear outside WTE, so the first WTE cycle sees a count of 0.
  router_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock  (clock),
    .resetn (resetn),
    .clr    (state_reg != WTE),
    .en     (state_reg == WTE),
    .tc     (wait_tc)
  );

  // Abort and a draining FIFO both take precedence over the timeout.
  assign timeout_fire = wait_tc && !dest_empty && !dest_soft;
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= DA;
      dest_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DA && pkt_valid) dest_addr_reg <= data_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      DA: begin
        if (pkt_valid && addr_valid && hdr_empty)  state_next = LFD;
        else if (pkt_valid && addr_valid)          state_next = WTE;
        else if (pkt_valid)                        state_next = DROP;
      end
      LFD:  state_next = LD;
      LD: begin
        if (fifo_full)       state_next = FFS;
        else if (!pkt_valid) state_next = LP;
      end
      FFS: begin
        if (!fifo_full) state_next = LAF;
      end
      LAF: begin
        if (parity_done)           state_next = DA;
        else if (low_packet_valid) state_next = LP;
        else                       state_next = LD;
      end
      LP:   state_next = CPE;
      CPE:  state_next = fifo_full ? FFS : DA;
      WTE: begin
        if (dest_empty)        state_next = LFD;
        else if (timeout_fire) state_next = DROP;
      end
      DROP: begin
        if (!pkt_valid) state_next = DA;
      end
      default: state_next = DA;
    endcase
    if (abort) state_next = DA;
  end

  assign dest_addr     = dest_addr_reg;
  assign detect_add    = (state_reg == DA);
  assign lfd_state     = (state_reg == LFD);
  assign ld_state      = (state_reg == LD);
  assign laf_state     = (state_reg == LAF);
  assign full_state    = (state_reg == FFS);
  assign rst_int_reg   = (state_reg == CPE);
  assign drop_state    = (state_reg == DROP);
  assign write_enb_reg = (state_reg == LD) || (state_reg == LAF) || (state_reg == LP);
  // Not busy in DA/LD/DROP so the source keeps streaming bytes.
  assign busy          = (state_reg == LFD) || (state_reg == FFS) || (state_reg == LAF) ||
                         (state_reg == LP)  || (state_reg == CPE) || (state_reg == WTE);
  assign timeout_pulse = timeout_fire;

endmodule

// File: tb/tb_router_fsm_np.sv
// ---------------------------------------------------------------------------
// tb_router_fsm_np
//   Directed bench for router_fsm_np. Instance u4 (NUM_PORTS=4,
//   TIMEOUT_CYCLES=8) covers the packet flows; instance u3 (NUM_PORTS=3)
//   covers invalid-address dropping. Outputs are checked 1 time unit after
//   the rising edge, packed as
//   {detect_add, lfd, ld, laf, full, rst_int, drop, write_enb, busy}.
// ---------------------------------------------------------------------------
module tb_router_fsm_np;

  localparam logic [8:0] E_DA   = 9'b100000000;
  localparam logic [8:0] E_LFD  = 9'b010000001;
  localparam logic [8:0] E_LD   = 9'b001000010;
  localparam logic [8:0] E_LAF  = 9'b000100011;
  localparam logic [8:0] E_FFS  = 9'b000010001;
  localparam logic [8:0] E_LP   = 9'b000000011;
  localparam logic [8:0] E_CPE  = 9'b000001001;
  localparam logic [8:0] E_WTE  = 9'b000000001;
  localparam logic [8:0] E_DROP = 9'b000000100;

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  // ---- 4-port instance ----
  logic       pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in, dest_addr;
  logic [3:0] fifo_empty, soft_reset;
  logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
  logic       full_state, rst_int_reg, busy, drop_state, timeout_pulse;

  router_fsm_np #(.NUM_PORTS(4), .TIMEOUT_CYCLES(8)) u4 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .dest_addr(dest_addr), .write_enb_reg(write_enb_reg), .detect_add(detect_add),
    .ld_state(ld_state), .laf_state(laf_state), .lfd_state(lfd_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy),
    .drop_state(drop_state), .timeout_pulse(timeout_pulse)
  );

  // ---- 3-port instance ----
  logic       pv3;
  logic [1:0] din3, dest3;
  logic [2:0] fe3;
  logic       wr3, da3, ld3, laf3, lfd3, full3, rst3, busy3, drop3, to3;

  router_fsm_np #(.NUM_PORTS(3)) u3 (
    .clock(clock), .resetn(resetn), .pkt_valid(pv3), .data_in(din3),
    .fifo_full(1'b0), .fifo_empty(fe3), .soft_reset(3'b000),
    .parity_done(1'b0), .low_packet_valid(1'b0),
    .dest_addr(dest3), .write_enb_reg(wr3), .detect_add(da3),
    .ld_state(ld3), .laf_state(laf3), .lfd_state(lfd3),
    .full_state(full3), .rst_int_reg(rst3), .busy(busy3),
    .drop_state(drop3), .timeout_pulse(to3)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  function automatic logic [8:0] obs4();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, drop_state, write_enb_reg, busy};
  endfunction

  function automatic logic [8:0] obs3();
    return {da3, lfd3, ld3, laf3, full3, rst3, drop3, wr3, busy3};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    pkt_valid = 0; data_in = 0; fifo_full = 0; fifo_empty = 0; soft_reset = 0;
    parity_done = 0; low_packet_valid = 0;
    pv3 = 0; din3 = 0; fe3 = 3'b111;

    // Reset state
    #3;
    check("rst_outs",  32'(obs4()), 32'(E_DA));
    check("rst_dest",  32'(dest_addr), 0);
    check("rst_to",    32'(timeout_pulse), 0);
    check("rst_outs3", 32'(obs3()), 32'(E_DA));
    step();
    resetn = 1'b1;

    // Idle DA with pkt_valid low holds DA
    step();
    check("idle_da", 32'(obs4()), 32'(E_DA));

    // Basic packet to port 2: DA->LFD->LD->LP->CPE->DA
    pkt_valid = 1; data_in = 2; fifo_empty = 4'b0100;
    step(); check("p1_lfd", 32'(obs4()), 32'(E_LFD));
    step(); check("p1_ld",  32'(obs4()), 32'(E_LD));
    pkt_valid = 0;
    step(); check("p1_lp",  32'(obs4()), 32'(E_LP));
    step(); check("p1_cpe", 32'(obs4()), 32'(E_CPE));
    step(); check("p1_da",  32'(obs4()), 32'(E_DA));
    check("p1_dest", 32'(dest_addr), 2);

    // FIFO-full stall for 3 cycles, LAF->LD, then LAF->DA on parity_done
    pkt_valid = 1;
    step(); check("p2_lfd", 32'(obs4()), 32'(E_LFD));
    step(); check("p2_ld",  32'(obs4()), 32'(E_LD));
    fifo_full = 1;
    for (int i = 1; i <= 3; i++) begin
      step(); check($sformatf("p2_ffs%0d", i), 32'(obs4()), 32'(E_FFS));
    end
    fifo_full = 0;
    step(); check("p2_laf",  32'(obs4()), 32'(E_LAF));
    step(); check("p2_ld2",  32'(obs4()), 32'(E_LD));
    fifo_full = 1;
    step(); check("p2_ffs4", 32'(obs4()), 32'(E_FFS));
    fifo_full = 0;
    step(); check("p2_laf2", 32'(obs4()), 32'(E_LAF));
    parity_done = 1;
    step(); check("p2_da",   32'(obs4()), 32'(E_DA));
    parity_done = 0; pkt_valid = 0;

    // Wait till empty on port 3, released after 5 WTE cycles
    pkt_valid = 1; data_in = 3; fifo_empty = 4'b0000;
    step();
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("p3_wte%0d", i), 32'(obs4()), 32'(E_WTE));
      if (i < 5) step();
    end
    fifo_empty = 4'b1000;
    step(); check("p3_lfd", 32'(obs4()), 32'(E_LFD));
    check("p3_dest", 32'(dest_addr), 3);
    pkt_valid = 0;
    step(); check("p3_ld",  32'(obs4()), 32'(E_LD));
    step(); check("p3_lp",  32'(obs4()), 32'(E_LP));
    step(); check("p3_cpe", 32'(obs4()), 32'(E_CPE));
    step(); check("p3_da",  32'(obs4()), 32'(E_DA));

    // WTE with fifo_empty and soft_reset both set -> DA
    pkt_valid = 1; data_in = 0; fifo_empty = 4'b0000;
    step(); check("p4_wte", 32'(obs4()), 32'(E_WTE));
    pkt_valid = 0; fifo_empty = 4'b0001; soft_reset = 4'b0001;
    step(); check("p4_da", 32'(obs4()), 32'(E_DA));
    soft_reset = 0;

    // Soft-reset abort in LD: other port ignored, own port aborts
    pkt_valid = 1; data_in = 1; fifo_empty = 4'b0010;
    step(); check("p5_lfd", 32'(obs4()), 32'(E_LFD));
    step(); check("p5_ld",  32'(obs4()), 32'(E_LD));
    soft_reset = 4'b0100;
    step(); check("p5_ld_other", 32'(obs4()), 32'(E_LD));
    soft_reset = 4'b0010;
    step(); check("p5_abort", 32'(obs4()), 32'(E_DA));
    check("p5_dest", 32'(dest_addr), 1);
    soft_reset = 0; pkt_valid = 0;

    // Asynchronous reset in LAF, observed before any clock edge
    pkt_valid = 1; data_in = 2; fifo_empty = 4'b0100;
    step(); step();
    fifo_full = 1;
    step();
    fifo_full = 0;
    step(); check("p6_laf", 32'(obs4()), 32'(E_LAF));
    #2 resetn = 1'b0;
    #1;
    check("p6_async_da",   32'(obs4()), 32'(E_DA));
    check("p6_async_dest", 32'(dest_addr), 0);
    pkt_valid = 0;
    step();
    resetn = 1'b1;
    step(); check("p6_da", 32'(obs4()), 32'(E_DA));

    // Wait timeout
    pkt_valid = 1; data_in = 2; fifo_empty = 4'b0000;
    step();
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("p7_wte%0d", i), 32'(obs4()), 32'(E_WTE));
      check($sformatf("p7_to%0d", i), 32'(timeout_pulse), (i == 8) ? 1 : 0);
      step();
    end
    check("p7_drop", 32'(obs4()), 32'(E_DROP));
    step(); check("p7_drop2", 32'(obs4()), 32'(E_DROP));
    pkt_valid = 0;
    step(); check("p7_da", 32'(obs4()), 32'(E_DA));
`else
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("p7_wte%0d", i), 32'(obs4()), 32'(E_WTE));
      check($sformatf("p7_to%0d", i), 32'(timeout_pulse), 0);
      step();
    end
    soft_reset = 4'b0100;
    step(); check("p7_abort", 32'(obs4()), 32'(E_DA));
    soft_reset = 0; pkt_valid = 0;
`endif

    // Invalid address on the 3-port instance: DROP while pkt_valid high
    pv3 = 1; din3 = 3;
    for (int i = 1; i <= 4; i++) begin
      step(); check($sformatf("p8_drop%0d", i), 32'(obs3()), 32'(E_DROP));
    end
    pv3 = 0;
    step(); check("p8_da", 32'(obs3()), 32'(E_DA));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
